// File: rtl/ir_scan_seq.sv
// ir_scan_seq: round-robin IR emitter/A2D scan sequencer producing a
// position-weighted, saturated signed line error for the motion controller.
module ir_scan_seq #(
    parameter int NUM_PAIRS  = 3,
    parameter int RES_W      = 12,
    parameter int CHNL_W     = 3,
    parameter int ERR_W      = 16,
    parameter int WSHIFT     = 1,
    parameter int SETTLE_CYC = 4096,
    parameter int PWM_W      = 8,
    parameter int DUTY       = 8'hC0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 cnv_cmplt,
    input  logic [RES_W-1:0]     A2D_res,
    output logic                 strt_cnv,
    output logic [CHNL_W-1:0]    chnnl,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [ERR_W-1:0]     err,
    output logic                 err_vld,
    output logic                 busy,
    output logic                 a2d_tmo
);
    localparam int KW    = NUM_PAIRS > 1 ? $clog2(NUM_PAIRS) : 1;
    localparam int ACC_W = RES_W + 1 + (NUM_PAIRS - 1) * WSHIFT + $clog2(NUM_PAIRS);
    localparam int WW    = ACC_W > ERR_W ? ACC_W : ERR_W;
    localparam int CW    = $clog2((SETTLE_CYC > TIMEOUT ? SETTLE_CYC : TIMEOUT) + 1);
    localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]        TMO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [KW-1:0]        K_LAST      = KW'(NUM_PAIRS - 1);
    localparam logic [PWM_W:0]       DUTY_V      = (PWM_W + 1)'(DUTY);
    localparam logic signed [WW-1:0] MAXV = {{(WW - ERR_W + 1){1'b0}}, {(ERR_W - 1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = {{(WW - ERR_W + 1){1'b1}}, {(ERR_W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, ACCUM, DONE} state_t;

    state_t                  state;
    logic [PWM_W-1:0]        pwm_cnt;
    logic [CW-1:0]           cnt;
    logic [KW-1:0]           k;
    logic [RES_W-1:0]        l_val, r_val;
    logic signed [RES_W:0]   diff;
    logic signed [ACC_W-1:0] acc, term;
    logic signed [WW-1:0]    acc_w;
    logic [ERR_W-1:0]        sat;
    logic                    go_q, lit;

    assign diff  = $signed({1'b0, r_val}) - $signed({1'b0, l_val});
    assign term  = {{(ACC_W - RES_W - 1){diff[RES_W]}}, diff} << (32'(k) * WSHIFT);
    assign acc_w = WW'(acc);
    assign sat   = acc_w > MAXV ? MAXV[ERR_W-1:0] : acc_w < MINV ? MINV[ERR_W-1:0] : acc_w[ERR_W-1:0];
    assign lit   = state inside {SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R};

    // cnt is shared: settle timer in SETTLE, timeout timer in WAIT_x; cleared on entry to each
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pwm_cnt  <= '0;
            cnt      <= '0;
            k        <= '0;
            l_val    <= '0;
            r_val    <= '0;
            acc      <= '0;
            go_q     <= 1'b0;
            strt_cnv <= 1'b0;
            chnnl    <= '0;
            IR_en    <= '0;
            err      <= '0;
            err_vld  <= 1'b0;
            busy     <= 1'b0;
            a2d_tmo  <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            cnt      <= cnt + 1'b1;
            go_q     <= go;
            strt_cnv <= 1'b0;
            err_vld  <= 1'b0;
            busy     <= state != IDLE;
            IR_en    <= (lit && ({1'b0, pwm_cnt} < DUTY_V)) ? (NUM_PAIRS'(1) << k) : '0;
            if (go && !go_q) a2d_tmo <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state <= SETTLE;
                    k     <= '0;
                    acc   <= '0;
                    cnt   <= '0;
                end
                SETTLE: if (cnt == SETTLE_LAST) begin
                    state    <= CNV_L;
                    strt_cnv <= 1'b1;
                    chnnl    <= CHNL_W'({k, 1'b0});
                end
                CNV_L: begin
                    state <= WAIT_L;
                    cnt   <= '0;
                end
                WAIT_L: if (cnv_cmplt) begin
                    l_val    <= A2D_res;
                    state    <= CNV_R;
                    strt_cnv <= 1'b1;
                    chnnl    <= CHNL_W'({k, 1'b1});
                end else if (cnt == TMO_LAST) begin
                    a2d_tmo <= 1'b1;
                    state   <= IDLE;
                end
                CNV_R: begin
                    state <= WAIT_R;
                    cnt   <= '0;
                end
                WAIT_R: if (cnv_cmplt) begin
                    r_val <= A2D_res;
                    state <= ACCUM;
                end else if (cnt == TMO_LAST) begin
                    a2d_tmo <= 1'b1;
                    state   <= IDLE;
                end
                ACCUM: begin
                    acc <= acc + term;
                    if (k == K_LAST) state <= DONE;
                    else begin
                        k     <= k + 1'b1;
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                DONE: begin
                    err     <= sat;
                    err_vld <= 1'b1;
                    state   <= go ? SETTLE : IDLE;
                    k       <= '0;
                    acc     <= '0;
                    cnt     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ir_scan_seq.sv
// tb_ir_scan_seq: directed bench for ir_scan_seq; dut_a uses ERR_W=16/short settle,
// dut_b uses ERR_W=12 with a settle long enough to observe a full PWM period.
module tb_ir_scan_seq;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst_n, go_a, go_b, cnv_cmplt;
    logic [11:0] A2D_res, l_val, r_val;
    logic        strt_cnv_a, strt_cnv_b, err_vld_a, err_vld_b, busy_a, busy_b, a2d_tmo_a, a2d_tmo_b;
    logic [2:0]  chnnl_a, chnnl_b, IR_en_a, IR_en_b, wch, sp_ch, ch;
    logic [15:0] err_a;
    logic [11:0] err_b;
    int          checks, errors, sp_dly, nvld_a, busy_drop, on_cnt, bad_cnt, base, n;
    bit          mon_busy;
    int          chq[$];

    always #5 clk = ~clk;

    ir_scan_seq #(.ERR_W(16), .SETTLE_CYC(16), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .go(go_a), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
        .strt_cnv(strt_cnv_a), .chnnl(chnnl_a), .IR_en(IR_en_a), .err(err_a),
        .err_vld(err_vld_a), .busy(busy_a), .a2d_tmo(a2d_tmo_a));

    ir_scan_seq #(.ERR_W(12), .SETTLE_CYC(300), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
        .strt_cnv(strt_cnv_b), .chnnl(chnnl_b), .IR_en(IR_en_b), .err(err_b),
        .err_vld(err_vld_b), .busy(busy_b), .a2d_tmo(a2d_tmo_b));

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic hit(input int sel);
        return sel == 0 ? err_vld_a : sel == 1 ? err_vld_b :
               sel == 2 ? (strt_cnv_a && chnnl_a == wch) :
               sel == 3 ? (strt_cnv_b && chnnl_b == wch) : a2d_tmo_a;
    endfunction

    task automatic wait_for(input int sel, input int lim, input string tag);
        int c = 0;
        while (!hit(sel) && c < lim) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(hit(sel)), 1);
    endtask

    // A2D model: answers the active DUT's request after 2 cycles, or sp_dly cycles on sp_ch
    initial begin
        cnv_cmplt = 1'b0;
        A2D_res   = '0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (strt_cnv_a || strt_cnv_b) begin
                ch = strt_cnv_a ? chnnl_a : chnnl_b;
                repeat ((ch == sp_ch) ? sp_dly : 2) @(negedge clk);
                A2D_res   = ch[0] ? r_val : l_val;
                cnv_cmplt = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (strt_cnv_a) chq.push_back(int'(chnnl_a));
        if (err_vld_a) nvld_a++;
        if (mon_busy && !busy_a) busy_drop++;
    end

    initial begin
        rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0; l_val = '0; r_val = '0;
        sp_ch = 3'd7; sp_dly = 2; wch = '0;
        repeat (3) @(negedge clk);
        check("rst_a_outs", {strt_cnv_a, chnnl_a, IR_en_a, err_vld_a, busy_a, a2d_tmo_a}, 0);
        check("rst_a_err", err_a, 0);
        check("rst_b_outs", {strt_cnv_b, chnnl_b, IR_en_b, err_vld_b, busy_b, a2d_tmo_b}, 0);
        check("rst_b_err", err_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single scan, latency, channel order
        l_val = 12'h100; r_val = 12'h300; chq.delete();
        go_a = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!strt_cnv_a && n < 100);
        check("t1_latency", n, 17);
        check("t1_busy", busy_a, 1);
        go_a = 1'b0;
        wait_for(0, 400, "t1_vld_seen");
        check("t1_err", $signed(err_a), 3584);
        repeat (40) @(negedge clk);
        check("t1_nvld", nvld_a, 1);
        check("t1_nch", chq.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("t1_ch%0d", i), i < chq.size() ? chq[i] : -1, i);
        check("t1_idle", busy_a, 0);

        // back-to-back scans with go held
        l_val = 12'h300; r_val = 12'h100; base = nvld_a; busy_drop = 0;
        go_a = 1'b1;
        repeat (2) @(negedge clk);
        mon_busy = 1'b1;
        wait_for(0, 400, "t3_v0_seen");
        check("t3_err0", $signed(err_a), -3584);
        l_val = 12'h100; r_val = 12'h300;
        @(negedge clk);
        wait_for(0, 400, "t3_v1_seen");
        check("t3_err1", $signed(err_a), 3584);
        l_val = 12'h300; r_val = 12'h100; go_a = 1'b0;
        @(negedge clk);
        wait_for(0, 400, "t3_v2_seen");
        check("t3_err2", $signed(err_a), -3584);
        mon_busy = 1'b0;
        check("t3_busy_drop", busy_drop, 0);
        repeat (100) @(negedge clk);
        check("t3_nvld", nvld_a - base, 3);
        check("t3_idle", busy_a, 0);

        // go dropped during pair 1 WAIT_L
        l_val = 12'h100; r_val = 12'h300; sp_ch = 3'd2; sp_dly = 20; base = nvld_a;
        go_a = 1'b1; wch = 3'd2;
        wait_for(2, 200, "t4_cnv2_seen");
        repeat (5) @(negedge clk);
        go_a = 1'b0;
        wait_for(0, 400, "t4_vld_seen");
        check("t4_err", $signed(err_a), 3584);
        check("t4_busy_at_vld", busy_a, 1);
        @(negedge clk);
        check("t4_busy_after", busy_a, 0);
        repeat (50) @(negedge clk);
        check("t4_nvld", nvld_a - base, 1);
        check("t4_still_idle", busy_a, 0);

        // timeout one cycle past the limit, then a response on exactly the last cycle
        sp_ch = 3'd3; sp_dly = TMO + 1;
        go_a = 1'b1; wch = 3'd3;
        wait_for(2, 200, "t5_cnv3_seen");
        go_a = 1'b0; base = nvld_a;
        wait_for(4, TMO + 100, "t5_tmo_seen");
        repeat (3) @(negedge clk);
        check("t5_tmo_sticky", a2d_tmo_a, 1);
        check("t5_ir_off", IR_en_a, 0);
        check("t5_idle", busy_a, 0);
        check("t5_err_kept", $signed(err_a), 3584);
        check("t5_no_vld", nvld_a - base, 0);
        l_val = 12'hFFF; r_val = 12'h000; sp_dly = TMO;
        go_a = 1'b1;
        @(negedge clk);
        check("t5_tmo_clr", a2d_tmo_a, 0);
        go_a = 1'b0;
        wait_for(0, 2000, "t5_edge_vld_seen");
        check("t5_edge_err", $signed(err_a), -28665);
        check("t5_edge_no_tmo", a2d_tmo_a, 0);
        sp_ch = 3'd7; sp_dly = 2;

        // ERR_W=12 saturation
        l_val = 12'h100; r_val = 12'h300;
        go_b = 1'b1; @(negedge clk); go_b = 1'b0;
        wait_for(1, 1500, "t2_pos_vld_seen");
        check("t2_sat_pos", $signed(err_b), 2047);
        repeat (3) @(negedge clk);
        l_val = 12'hFFF; r_val = 12'h000;
        go_b = 1'b1; @(negedge clk); go_b = 1'b0;
        wait_for(1, 1500, "t2_neg_vld_seen");
        check("t2_sat_neg", $signed(err_b), -2048);
        repeat (3) @(negedge clk);

        // PWM duty during pair 2 settle, then asynchronous reset
        l_val = 12'h100; r_val = 12'h300; wch = 3'd3; on_cnt = 0; bad_cnt = 0;
        go_b = 1'b1; @(negedge clk); go_b = 1'b0;
        wait_for(3, 1500, "t6_cnv3_seen");
        repeat (10) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            if (IR_en_b == 3'b100) on_cnt++;
            else if (IR_en_b != 3'b000) bad_cnt++;
            @(negedge clk);
        end
        check("t6_duty_on", on_cnt, 192);
        check("t6_duty_bad", bad_cnt, 0);
        check("t6_busy", busy_b, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ir", IR_en_b, 0);
        check("t6_rst_busy", busy_b, 0);
        check("t6_rst_err", err_b, 0);
        check("t6_rst_ch", chnnl_b, 0);
        check("t6_rst_misc", {strt_cnv_b, err_vld_b, a2d_tmo_b}, 0);
        check("t6_rst_a_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_post_rst_idle", {busy_b, IR_en_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_scan_seq.md
Name: ir_scan_seq

Overview:
Parametrised round-robin IR sensor scan sequencer for the line-follower digital core. It replaces the fixed three-pair inner/mid/outer scheme with NUM_PAIRS left/right sensor pairs. For each pair it PWM-enables the pair's emitters, waits a settle time, then requests two A2D conversions. It accumulates a signed, position-weighted line error for the motion controller and flags A2D timeouts.

Parameters:
NUM_PAIRS, 3, number of left/right IR sensor pairs; pair k uses channel 2k (left) and 2k+1 (right).
RES_W, 12, A2D result width (unsigned).
CHNL_W, 3, width of chnnl; must satisfy 2^CHNL_W >= 2*NUM_PAIRS.
ERR_W, 16, width of signed error output.
WSHIFT, 1, per-pair weight shift; pair k difference is weighted by 2^(k*WSHIFT).
SETTLE_CYC, 4096, emitter settle cycles before the first conversion of each pair.
PWM_W, 8, emitter PWM counter width.
DUTY, 8'hC0, emitter PWM duty: enable is high while pwm_cnt < DUTY.
TIMEOUT, 1024, maximum cycles to wait for cnv_cmplt.

Ports:
clk  input  1  system clock (50MHz)
rst_n  input  1  asynchronous active-low reset
go  input  1  level; scanning runs while high
cnv_cmplt  input  1  A2D conversion complete strobe
A2D_res  input  RES_W  A2D result, valid when cnv_cmplt=1
strt_cnv  output  1  one-cycle conversion request
chnnl  output  CHNL_W  channel for the current conversion
IR_en  output  NUM_PAIRS  PWM emitter enables, one per pair
err  output  ERR_W  signed weighted error, saturated
err_vld  output  1  one-cycle strobe when err updates
busy  output  1  high whenever the state is not IDLE
a2d_tmo  output  1  sticky timeout flag; cleared by rst_n or by the next rising edge of go

Behaviour:
- Reset (async, rst_n low): state IDLE, all counters 0, strt_cnv=0, chnnl=0, IR_en=0, err=0, err_vld=0, busy=0, a2d_tmo=0, accumulator=0, pair index k=0.
- pwm_cnt is a free-running PWM_W-bit counter that wraps. IR_en[k] = (state in SETTLE..WAIT_R) && (k == current pair) && (pwm_cnt < DUTY). All other bits are 0. IR_en is registered.
- States and transitions:
  - IDLE → SETTLE on go=1, with k=0 and acc=0.
  - SETTLE counts SETTLE_CYC cycles, then → CNV_L.
  - CNV_L: strt_cnv=1 for exactly one cycle, chnnl=2k; → WAIT_L.
  - WAIT_L: on cnv_cmplt, capture L=A2D_res and → CNV_R.
  - CNV_R: strt_cnv=1 for one cycle, chnnl=2k+1; → WAIT_R.
  - WAIT_R: on cnv_cmplt, capture R and → ACCUM.
  - ACCUM: acc += sign-extend(R-L) << (k*WSHIFT). If k < NUM_PAIRS-1, k++ and → SETTLE. Otherwise → DONE.
  - DONE: err <= sat(acc), err_vld=1 for one cycle. If go=1, → SETTLE with k=0 and acc cleared; otherwise → IDLE.
- Latency: with go sampled at edge n, strt_cnv is high in cycle n+SETTLE_CYC+1.
- chnnl is held stable from CNV_x through WAIT_x.
- cnv_cmplt is ignored outside WAIT_L/WAIT_R, including the same cycle strt_cnv is asserted.
- Arithmetic: R-L is RES_W+1 signed. acc has width RES_W+1+(NUM_PAIRS-1)*WSHIFT+ceil(log2(NUM_PAIRS)) and never overflows internally. Saturation clamps to [-2^(ERR_W-1), 2^(ERR_W-1)-1].
- go deasserted mid-scan: the current scan completes and err_vld fires, then → IDLE. No partial results are emitted.
- Timeout: a wait counter is cleared on entry to each WAIT state. Reaching TIMEOUT without cnv_cmplt sets a2d_tmo=1 and → IDLE. err is left unchanged, no err_vld is issued, and IR_en goes to 0.
- Simultaneous cnv_cmplt on the TIMEOUT cycle: cnv_cmplt wins and no timeout is flagged.
- Reset mid-operation aborts immediately to the reset values.

Test Plan:
1. NUM_PAIRS=3, SETTLE_CYC=16. A2D model returns L=0x100, R=0x300 for every pair → one err_vld with err=0x0E00 (3584). The strt_cnv sequence has chnnl 0,1,2,3,4,5, and the first strt_cnv comes 17 cycles after go.
2. Same stimulus with ERR_W=12 → err=0x7FF (saturated positive). With L=0xFFF, R=0: ERR_W=16 gives err=-28665; ERR_W=12 gives err=-2048.
3. go held high for 3 scans with alternating stimulus L/R=0x300/0x100 then 0x100/0x300 → err sequence -3584, 3584, -3584. Exactly one err_vld per scan; busy stays high throughout.
4. Drop go during pair 1 WAIT_L → the scan finishes with err_vld, then IDLE, and busy falls the cycle after err_vld.
5. Withhold cnv_cmplt on channel 3 for TIMEOUT cycles → a2d_tmo=1, IDLE, IR_en=0, err unchanged. The next go rise clears a2d_tmo. Also drive cnv_cmplt on exactly the TIMEOUT cycle → no flag.
6. DUTY=0xC0: during SETTLE of pair 2, IR_en=3'b100 for 192 of each 256 cycles and 3'b000 otherwise. Assert rst_n low mid-SETTLE → all outputs are 0 asynchronously.
